// File: rtl/spi_slave_rx_if.sv
// SPIbus: single-master serial bus with a 2-bit slave-select code.
// The master drives every wire; slaves only observe.
interface SPIbus;
  logic       mosi;
  logic       sck;
  logic [1:0] ss;

  modport Master (output mosi, output sck, output ss);
  modport Slave  (input  mosi, input  sck, input  ss);
endinterface

// File: rtl/spi_slave_rx.sv
// Receive-only SPI slave, oversampled in the Clk_i domain, LSB first.
// A finished byte is held in a valid/ack register with sticky overrun and timeout-abort reporting.
module spi_slave_rx #(
  parameter logic [1:0] SLAVE_ID = 2'd0,
  parameter logic [7:0] TIMEOUT  = 8'd64
) (
  input  logic       Clk_i,
  input  logic       Rst_ni,
  SPIbus.Slave       Spis,
  output logic [7:0] Data_o,
  output logic       Valid_o,
  input  logic       Ack_i,
  output logic       Overrun_o,
  output logic       Busy_o,
  output logic       Timeout_o
);

  typedef enum logic {IDLE, RECV} state_e;

  state_e     state_q, state_d;
  logic       sck_s1_q, sck_s2_q, sck_d_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [1:0] ss_s1_q, ss_s2_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       timeout_q, timeout_d;

  logic       rise, sel, done;
  logic [7:0] byte_w;

  assign rise = sck_s2_q & ~sck_d_q;
  assign sel  = (ss_s2_q == SLAVE_ID);

  // Bit 7 arrives on the completion edge, so the finished byte merges it in directly.
  always_comb begin
    byte_w    = shift_q;
    byte_w[7] = mosi_s2_q;
  end

  always_ff @(posedge Clk_i) begin
    if (!Rst_ni) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_d_q   <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      ss_s1_q   <= 2'd0;
      ss_s2_q   <= 2'd0;
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bitcnt_q  <= 3'd0;
      tcnt_q    <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sck_s1_q  <= Spis.sck;
      sck_s2_q  <= sck_s1_q;
      sck_d_q   <= sck_s2_q;
      mosi_s1_q <= Spis.mosi;
      mosi_s2_q <= mosi_s1_q;
      ss_s1_q   <= Spis.ss;
      ss_s2_q   <= ss_s1_q;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      tcnt_q    <= tcnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise && sel) begin
          shift_d  = {7'd0, mosi_s2_q};
          bitcnt_d = 3'd1;
          tcnt_d   = 8'h00;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (!sel) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          bitcnt_d  = 3'd0;
          shift_d   = 8'h00;
        end else if (rise) begin
          shift_d[bitcnt_q] = mosi_s2_q;
          bitcnt_d          = bitcnt_q + 3'd1;
          tcnt_d            = 8'h00;
          if (bitcnt_q == 3'd7) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else if (tcnt_q >= TIMEOUT - 8'd1) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          bitcnt_d  = 3'd0;
          shift_d   = 8'h00;
        end else if (tcnt_q != 8'hFF) begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An ack landing on the completion cycle frees the slot for the new byte.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (done) begin
      if (!valid_q || Ack_i) begin
        data_d  = byte_w;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (Ack_i && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign Data_o    = data_q;
  assign Valid_o   = valid_q;
  assign Overrun_o = overrun_q;
  assign Busy_o    = (state_q == RECV);
  assign Timeout_o = timeout_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: hand-modelled SPI master, scoreboard of expected bytes.
module tb_spi_slave_rx;
  localparam logic [1:0] SID = 2'b01;
  localparam int         TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, busy, tmo;

  SPIbus spi ();

  spi_slave_rx #(.SLAVE_ID(SID), .TIMEOUT(8'(TMO))) dut (
    .Clk_i    (clk),
    .Rst_ni   (rst_n),
    .Spis     (spi),
    .Data_o   (data),
    .Valid_o  (valid),
    .Ack_i    (ack),
    .Overrun_o(overrun),
    .Busy_o   (busy),
    .Timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         to_pulses = 0;
  int         to_cycles = 0;
  logic       busy_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a new byte lands in the holding register.
  initial begin
    logic       vprev, tprev;
    logic [7:0] dprev, e;
    vprev = 1'b0; tprev = 1'b0; dprev = 8'h00;
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (tmo) to_cycles++;
      if (tmo && !tprev) to_pulses++;
      if (rst_n && valid && (!vprev || data != dprev)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_extra_byte got=%0h exp=none", data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {24'h0, data}, {24'h0, e});
        end
      end
      vprev = valid; tprev = tmo; dprev = data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // One sck period; mosi changes while sck is low. Optionally acks on the completion cycle.
  task automatic sck_pulse(input logic b, input bit ack_end);
    spi.mosi = b;
    spi.sck  = 1'b0;
    repeat (2) @(posedge clk);
    #1 spi.sck = 1'b1;
    if (ack_end) begin
      @(posedge clk);
      @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
    end else begin
      repeat (2) @(posedge clk);
      #1;
    end
    spi.sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] ss, input bit push, input bit ack_end);
    if (push) exp_q.push_back(b);
    spi.ss = ss;
    for (int i = 0; i < 8; i++) sck_pulse(b[i], ack_end && (i == 7));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {31'h0, valid}, 32'h1);
  endtask

  initial begin
    spi.sck = 1'b0; spi.mosi = 1'b0; spi.ss = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'h0, data}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_timeout", {31'h0, tmo}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Other slave addressed: nothing happens here
    busy_seen = 1'b0;
    send_byte(8'h3C, 2'b10, 1'b0, 1'b0);
    chk("t2_busy_seen", {31'h0, busy_seen}, 32'h0);
    chk("t2_valid", {31'h0, valid}, 32'h0);
    chk("t2_data", {24'h0, data}, 32'h0);

    // Basic byte, held until ack
    send_byte(8'hA5, SID, 1'b1, 1'b0);
    wait_valid("t1_valid");
    chk("t1_overrun", {31'h0, overrun}, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("t1_hold_valid", {31'h0, valid}, 32'h1);
    chk("t1_hold_data", {24'h0, data}, 32'hA5);
    ack_pulse();
    chk("t1_ack_valid", {31'h0, valid}, 32'h0);
    chk("t1_no_timeout", to_pulses, 0);

    // Overrun: second byte dropped while first is unacknowledged
    send_byte(8'h12, SID, 1'b1, 1'b0);
    send_byte(8'h34, SID, 1'b0, 1'b0);
    chk("t3_data", {24'h0, data}, 32'h12);
    chk("t3_valid", {31'h0, valid}, 32'h1);
    chk("t3_overrun", {31'h0, overrun}, 32'h1);
    ack_pulse();
    chk("t3_ack_valid", {31'h0, valid}, 32'h0);
    chk("t3_ack_overrun", {31'h0, overrun}, 32'h0);
    send_byte(8'h56, SID, 1'b1, 1'b0);
    wait_valid("t3_valid2");
    chk("t3_data2", {24'h0, data}, 32'h56);
    ack_pulse();

    // Partial frame then silence: timeout abort
    busy_seen = 1'b0;
    sck_pulse(1'b1, 1'b0);
    sck_pulse(1'b0, 1'b0);
    sck_pulse(1'b1, 1'b0);
    repeat (TMO + 4) @(posedge clk);
    #1;
    chk("t4_busy_seen", {31'h0, busy_seen}, 32'h1);
    chk("t4_to_pulses", to_pulses, 1);
    chk("t4_to_width", to_cycles, 1);
    chk("t4_busy", {31'h0, busy}, 32'h0);
    chk("t4_valid", {31'h0, valid}, 32'h0);
    send_byte(8'hC3, SID, 1'b1, 1'b0);
    wait_valid("t4_valid2");
    chk("t4_data2", {24'h0, data}, 32'hC3);
    ack_pulse();

    // Reset mid-frame after four bits of 8'hF0
    for (int i = 0; i < 4; i++) sck_pulse(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_busy_mid", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_rst_data", {24'h0, data}, 32'h0);
    chk("t5_rst_valid", {31'h0, valid}, 32'h0);
    chk("t5_rst_overrun", {31'h0, overrun}, 32'h0);
    chk("t5_rst_busy", {31'h0, busy}, 32'h0);
    chk("t5_rst_timeout", {31'h0, tmo}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h5A, SID, 1'b1, 1'b0);
    wait_valid("t5_valid");
    chk("t5_data", {24'h0, data}, 32'h5A);
    ack_pulse();

    // Ack coincident with completion replaces the held byte
    send_byte(8'h11, SID, 1'b1, 1'b0);
    wait_valid("t6_valid1");
    send_byte(8'h22, SID, 1'b1, 1'b1);
    chk("t6_data", {24'h0, data}, 32'h22);
    chk("t6_valid", {31'h0, valid}, 32'h1);
    chk("t6_overrun", {31'h0, overrun}, 32'h0);
    ack_pulse();
    chk("t6_ack_valid", {31'h0, valid}, 32'h0);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("total_timeouts", to_pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Receive-only SPI slave that deserialises the byte stream driven by the team's SPI master onto the SPIbus interface. It is oversampled in the local Clk_i domain: sck, mosi and ss are synchronised, and mosi is sampled on detected sck rising edges, LSB first. A completed byte is presented on a valid/ack holding register, with overrun and timeout reporting. It sits on the slave side of SPIbus, one instance per slave ID.

Parameters:
SLAVE_ID, 2'd0, ss value that selects this slave.
TIMEOUT, 8'd64, Clk_i cycles without an sck rising edge mid-frame before the frame is aborted.

Ports:
Clk_i  input  1  system clock, all logic on rising edge
Rst_ni  input  1  synchronous active-low reset
Spis  SPIbus.Slave  -  mosi (1), sck (1), ss (2); all inputs to this block
Data_o  output  8  last accepted received byte
Valid_o  output  1  Data_o holds an unacknowledged byte
Ack_i  input  1  consumer acknowledge; clears Valid_o
Overrun_o  output  1  sticky: a byte completed while Valid_o=1 and was dropped
Busy_o  output  1  frame in progress (state RECV)
Timeout_o  output  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: synchronous, sampled on the Clk_i rising edge while Rst_ni=0. It clears the synchronisers, the shift register, bitcnt, the timeout counter and state (to IDLE). Data_o=8'h00; Valid_o, Overrun_o, Busy_o and Timeout_o are all 0. Reset mid-frame discards the partial byte.
- Synchronisation:
  - sck, mosi and ss each pass through 2 flops (s1, s2). sck_d is a register of sck_s2.
  - rise = sck_s2 & ~sck_d.
  - sel = (ss_s2 == SLAVE_ID).
- Input timing: sck high and low phases must each be ≥2 Clk_i cycles. The master at CLKDIV≥4 meets this.
- State IDLE:
  - Busy_o=0. On rise & sel: shift[0] <= mosi_s2, bitcnt <= 1, tcnt <= 0, go to RECV.
  - rise with !sel is ignored.
- State RECV:
  - Busy_o=1. Each rise & sel: shift[bitcnt] <= mosi_s2, bitcnt+1, tcnt <= 0.
  - On the rise that captures bit 7: the byte is complete, go to IDLE.
  - Abort: if !sel, or tcnt reaches TIMEOUT-1 with no rise, go to IDLE. The partial byte is discarded and Timeout_o pulses for 1 cycle. An abort caused by !sel also pulses Timeout_o.
  - tcnt increments every cycle without a rise and saturates.
- Byte completion (registered on the same edge as bit 7 capture):
  - Valid_o=0, or Ack_i=1 in that cycle: Data_o <= byte, Valid_o <= 1.
  - Valid_o=1 and Ack_i=0: byte dropped, Data_o unchanged, Overrun_o <= 1.
- Ack_i with no completion in the same cycle: Valid_o <= 0, Overrun_o <= 0. Ack_i with Valid_o=0 has no effect.
- Latency: Valid_o rises 2 Clk_i cycles after the edge at which raw sck is first sampled high for the 8th bit.
- Bit ordering: the first received bit is Data_o[0], matching the master's right-shifting buffer.
- Widths: bitcnt is 3 bits; 0..7 in RECV. tcnt is 8 bits and saturates at 8'hFF.

Test Plan:
1. Master CLKDIV=4, ss_i=SLAVE_ID=2'b01, Buf_i=8'hA5, strobe -> Data_o=8'hA5, Valid_o=1 held until Ack_i, Overrun_o=0, Timeout_o never pulses; Ack_i -> Valid_o=0 next cycle.
2. SLAVE_ID=2'b01, master sends 8'h3C with ss=2'b10 -> Busy_o stays 0, Valid_o stays 0, Data_o=8'h00.
3. Send 8'h12 then 8'h34 with no Ack_i -> Data_o=8'h12, Overrun_o=1; then Ack_i -> Valid_o=0, Overrun_o=0; then send 8'h56 -> Data_o=8'h56.
4. Hand-driven sck: 3 pulses, then idle for TIMEOUT+2 cycles -> Timeout_o one-cycle pulse, Busy_o=0, no Valid_o; then full byte 8'hC3 -> Data_o=8'hC3.
5. Drive Rst_ni=0 for 1 cycle after 4 bits of 8'hF0 -> all outputs 0 the next cycle; then 8'h5A -> Data_o=8'h5A, Valid_o=1.
6. With Valid_o=1 (8'h11), assert Ack_i on the exact cycle 8'h22 completes -> Data_o=8'h22, Valid_o stays 1, Overrun_o=0.
